// File: rtl/cond_exec_stage.sv
// Execute-stage condition unit: NZCV register, condition evaluation and gating of
// write/branch/PC-source controls into the Memory stage. Optional macro COND_STATS_EN adds counters.

module condcheck (
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);
    logic n, z, c, v, ge;

    always_comb begin
        {n, z, c, v} = flags;
        ge = (n == v);
        case (cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = ~c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = c & ~z;
            4'b1001: cond_ex = ~(c & ~z);
            4'b1010: cond_ex = ge;
            4'b1011: cond_ex = ~ge;
            4'b1100: cond_ex = ~z & ge;
            4'b1101: cond_ex = ~(~z & ge);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end
endmodule

module cond_exec_stage #(
    parameter logic [3:0] FLAG_RESET = 4'b0000,
    parameter int         STAT_W     = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ValidE,
    input  logic       StallE,
    input  logic       KillE,
    input  logic [3:0] CondE,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagWriteE,
    input  logic       RegWriteE,
    input  logic       MemWriteE,
    input  logic       PCSrcE,
    input  logic       BranchE,
    output logic       CondExE,
    output logic       BranchTakenE,
    output logic [3:0] Flags,
    output logic       RegWriteM,
    output logic       MemWriteM,
    output logic       PCSrcM,
    output logic       BranchTakenM,
    output logic       UndefCond
`ifdef COND_STATS_EN
   ,output logic [STAT_W-1:0] ExecCount,
    output logic [STAT_W-1:0] AnnulCount
`endif
);
    logic [3:0] flags_q, flags_d;
    logic       reg_write_q, reg_write_d;
    logic       mem_write_q, mem_write_d;
    logic       pc_src_q, pc_src_d;
    logic       branch_taken_q, branch_taken_d;
    logic       undef_q, undef_d;
    logic       live, cc_ok, cond_ex, branch_taken;

    condcheck u_condcheck (
        .cond    (CondE),
        .flags   (flags_q),
        .cond_ex (cc_ok)
    );

    // Cond=1111 is masked here so it never executes regardless of condcheck's decode.
    always_comb begin
        live         = ValidE & ~KillE;
        cond_ex      = live & (CondE != 4'b1111) & cc_ok;
        branch_taken = BranchE & cond_ex;

        flags_d = flags_q;
        if (cond_ex && !StallE) begin
            if (FlagWriteE[1]) flags_d[3:2] = ALUFlags[3:2];
            if (FlagWriteE[0]) flags_d[1:0] = ALUFlags[1:0];
        end

        reg_write_d    = reg_write_q;
        mem_write_d    = mem_write_q;
        pc_src_d       = pc_src_q;
        branch_taken_d = branch_taken_q;
        if (KillE) begin
            reg_write_d    = 1'b0;
            mem_write_d    = 1'b0;
            pc_src_d       = 1'b0;
            branch_taken_d = 1'b0;
        end else if (!StallE) begin
            reg_write_d    = RegWriteE & cond_ex;
            mem_write_d    = MemWriteE & cond_ex;
            pc_src_d       = PCSrcE & cond_ex;
            branch_taken_d = branch_taken;
        end

        undef_d = undef_q | (live & ~StallE & (CondE == 4'b1111));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flags_q        <= FLAG_RESET;
            reg_write_q    <= 1'b0;
            mem_write_q    <= 1'b0;
            pc_src_q       <= 1'b0;
            branch_taken_q <= 1'b0;
            undef_q        <= 1'b0;
        end else begin
            flags_q        <= flags_d;
            reg_write_q    <= reg_write_d;
            mem_write_q    <= mem_write_d;
            pc_src_q       <= pc_src_d;
            branch_taken_q <= branch_taken_d;
            undef_q        <= undef_d;
        end
    end

`ifdef COND_STATS_EN
    logic [STAT_W-1:0] exec_cnt_q, exec_cnt_d;
    logic [STAT_W-1:0] annul_cnt_q, annul_cnt_d;

    always_comb begin
        exec_cnt_d  = exec_cnt_q;
        annul_cnt_d = annul_cnt_q;
        if (live && !StallE) begin
            if (cond_ex) begin
                if (!(&exec_cnt_q)) exec_cnt_d = exec_cnt_q + 1'b1;
            end else begin
                if (!(&annul_cnt_q)) annul_cnt_d = annul_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            exec_cnt_q  <= '0;
            annul_cnt_q <= '0;
        end else begin
            exec_cnt_q  <= exec_cnt_d;
            annul_cnt_q <= annul_cnt_d;
        end
    end

    assign ExecCount  = exec_cnt_q;
    assign AnnulCount = annul_cnt_q;
`endif

    assign CondExE      = cond_ex;
    assign BranchTakenE = branch_taken;
    assign Flags        = flags_q;
    assign RegWriteM    = reg_write_q;
    assign MemWriteM    = mem_write_q;
    assign PCSrcM       = pc_src_q;
    assign BranchTakenM = branch_taken_q;
    assign UndefCond    = undef_q;
endmodule

// File: tb/tb_cond_exec_stage.sv
// Self-checking bench for cond_exec_stage: directed steps plus random traffic against an
// ARM condition-rule reference model; statistics checks compiled in with COND_STATS_EN.

module tb_cond_exec_stage;
    localparam int STAT_W = 16;
    localparam int STAT_MAX = (1 << STAT_W) - 1;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ValidE = 1'b0, StallE = 1'b0, KillE = 1'b0;
    logic [3:0] CondE = 4'h0, ALUFlags = 4'h0;
    logic [1:0] FlagWriteE = 2'b00;
    logic       RegWriteE = 1'b0, MemWriteE = 1'b0, PCSrcE = 1'b0, BranchE = 1'b0;
    logic       CondExE, BranchTakenE, RegWriteM, MemWriteM, PCSrcM, BranchTakenM, UndefCond;
    logic [3:0] Flags;
`ifdef COND_STATS_EN
    logic [STAT_W-1:0] ExecCount, AnnulCount;
`endif

    cond_exec_stage #(.FLAG_RESET(4'b0000), .STAT_W(STAT_W)) dut (
        .clk(clk), .reset_n(reset_n), .ValidE(ValidE), .StallE(StallE), .KillE(KillE),
        .CondE(CondE), .ALUFlags(ALUFlags), .FlagWriteE(FlagWriteE), .RegWriteE(RegWriteE),
        .MemWriteE(MemWriteE), .PCSrcE(PCSrcE), .BranchE(BranchE), .CondExE(CondExE),
        .BranchTakenE(BranchTakenE), .Flags(Flags), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .PCSrcM(PCSrcM), .BranchTakenM(BranchTakenM), .UndefCond(UndefCond)
`ifdef COND_STATS_EN
       ,.ExecCount(ExecCount), .AnnulCount(AnnulCount)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state
    logic       m_known = 1'b0;
    logic [3:0] m_flags;
    logic       m_rw, m_mw, m_pc, m_bt, m_undef;
    int         m_exec, m_annul;
    logic       obs_cex, obs_bte;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ARM rule: pairs of codes share a predicate, odd code is its negation; AL is 1110.
    function automatic logic passes(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cond[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (cond == 4'b1111) return 1'b0;
        return cond[0] ? !base : base;
    endfunction

    task automatic step(input logic rst_n, input logic valid, input logic stall, input logic kill,
                        input logic [3:0] cond, input logic [3:0] alu, input logic [1:0] fw,
                        input logic rw, input logic mw, input logic pc, input logic br);
        logic live, ex;
        reset_n = rst_n; ValidE = valid; StallE = stall; KillE = kill; CondE = cond;
        ALUFlags = alu; FlagWriteE = fw; RegWriteE = rw; MemWriteE = mw; PCSrcE = pc; BranchE = br;
        #1;
        live = valid && !kill;
        ex = live && m_known && passes(cond, m_flags);
        obs_cex = CondExE;
        obs_bte = BranchTakenE;
        if (m_known) begin
            chk("cond_ex_e", CondExE, ex);
            chk("branch_taken_e", BranchTakenE, br && ex);
            chk("flags_e", Flags, m_flags);
        end
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_known = 1'b1; m_flags = 4'b0000;
            m_rw = 0; m_mw = 0; m_pc = 0; m_bt = 0; m_undef = 0;
            m_exec = 0; m_annul = 0;
        end else if (m_known) begin
            if (ex && !stall) begin
                if (fw[1]) m_flags[3:2] = alu[3:2];
                if (fw[0]) m_flags[1:0] = alu[1:0];
            end
            if (kill) begin
                m_rw = 0; m_mw = 0; m_pc = 0; m_bt = 0;
            end else if (!stall) begin
                m_rw = rw && ex; m_mw = mw && ex; m_pc = pc && ex; m_bt = br && ex;
            end
            if (live && !stall && cond == 4'b1111) m_undef = 1'b1;
            if (live && !stall) begin
                if (ex) begin if (m_exec < STAT_MAX) m_exec++; end
                else    begin if (m_annul < STAT_MAX) m_annul++; end
            end
        end
        if (m_known) begin
            chk("flags", Flags, m_flags);
            chk("reg_write_m", RegWriteM, m_rw);
            chk("mem_write_m", MemWriteM, m_mw);
            chk("pc_src_m", PCSrcM, m_pc);
            chk("branch_taken_m", BranchTakenM, m_bt);
            chk("undef_cond", UndefCond, m_undef);
`ifdef COND_STATS_EN
            chk("exec_count", ExecCount, m_exec);
            chk("annul_count", AnnulCount, m_annul);
`endif
        end
        @(negedge clk);
    endtask

    task automatic rnd_step(input logic rst_n);
        step(rst_n, 1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
             4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom));
    endtask

    // Shorthand for an unstalled, unkilled live instruction.
    task automatic ins(input logic [3:0] cond, input logic [3:0] alu, input logic [1:0] fw,
                       input logic rw, input logic mw, input logic br);
        step(1, 1, 0, 0, cond, alu, fw, rw, mw, 1'b0, br);
    endtask

    initial begin
        int saved;
        // Reset with random inputs, then CondExE under Flags=0000
        rnd_step(0);
        rnd_step(0);
        step(0, 1, 0, 0, 4'b0000, 4'h0, 2'b00, 0, 0, 0, 0);
        chk("reset_eq", obs_cex, 1'b0);
        step(0, 1, 0, 0, 4'b0001, 4'h0, 2'b00, 0, 0, 0, 0);
        chk("reset_ne", obs_cex, 1'b1);
        chk("reset_flags", Flags, 4'b0000);
        chk("reset_undef", UndefCond, 1'b0);

        // Flag write then dependent branch
        ins(4'b1110, 4'b0100, 2'b11, 0, 0, 0);
        chk("subs_flags", Flags, 4'b0100);
        ins(4'b0000, 4'h0, 2'b00, 0, 0, 1);
        chk("beq_taken_e", obs_bte, 1'b1);
        chk("beq_taken_m", BranchTakenM, 1'b1);

        // Partial flag write
        ins(4'b1110, 4'b1010, 2'b11, 0, 0, 0);
        ins(4'b1110, 4'b0101, 2'b10, 0, 0, 0);
        chk("partial_flags", Flags, 4'b0110);

        // Annulled instruction
        ins(4'b1110, 4'b0000, 2'b11, 0, 0, 0);
        ins(4'b0000, 4'b1111, 2'b11, 1, 1, 0);
        chk("annul_cex", obs_cex, 1'b0);
        chk("annul_rw", RegWriteM, 1'b0);
        chk("annul_mw", MemWriteM, 1'b0);
        chk("annul_flags", Flags, 4'b0000);

        // Stall then kill
        ins(4'b1110, 4'h0, 2'b00, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            ins(4'b0000, 4'h0, 2'b00, 0, 0, 0);
            step(1, 1, 1, 0, 4'b1110, 4'b1111, 2'b11, 1, 0, 0, 0);
        end
        ins(4'b1110, 4'h0, 2'b00, 1, 0, 0);
        for (int i = 0; i < 3; i++)
            step(1, 1, 1, 0, 4'b1110, 4'b1111, 2'b11, 0, 0, 0, 0);
        chk("stall_rw_hold", RegWriteM, 1'b1);
        chk("stall_flags", Flags, 4'b0000);
        step(1, 1, 1, 1, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 1);
        chk("kill_rw", RegWriteM, 1'b0);
        chk("kill_flags", Flags, 4'b0000);

        // Cond=1111
        saved = m_annul;
        ins(4'b1111, 4'h0, 2'b00, 1, 0, 0);
        chk("nv_cex", obs_cex, 1'b0);
        chk("nv_rw", RegWriteM, 1'b0);
        chk("nv_undef", UndefCond, 1'b1);
        ins(4'b1110, 4'h0, 2'b00, 1, 0, 0);
        ins(4'b0001, 4'h0, 2'b00, 1, 0, 0);
        chk("nv_undef_sticky", UndefCond, 1'b1);
`ifdef COND_STATS_EN
        chk("nv_annul_inc", AnnulCount, saved + 1);
        for (int i = 0; i < STAT_MAX + 4; i++)
            ins(4'b1110, 4'h0, 2'b00, 1, 0, 0);
        chk("exec_saturated", ExecCount, STAT_MAX);
`endif

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++)
            rnd_step($urandom_range(0, 40) != 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
